// File: rtl/scan_pkg.sv
// Shared definitions for the mux scan serializer: FSM state encoding and
// beat-count constants. Optional feature macro: SCAN_PARITY_EN.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int SCAN_BEATS     = 4;
    localparam int SCAN_BEATS_PAR = 5;

    // Serial beats produced per accepted word in this build.
`ifdef SCAN_PARITY_EN
    localparam int BEATS_PER_WORD = SCAN_BEATS_PAR;
`else
    localparam int BEATS_PER_WORD = SCAN_BEATS;
`endif

endpackage

// File: rtl/sel_counter2.sv
// 2-bit mux select counter with synchronous clear and enable.
// Ports: clk, rst_n (sync, active-low), clr, en -> cnt[1:0], term (cnt==3).
module sel_counter2
    import scan_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic [1:0] cnt,
    output logic       term
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= 2'd0;
        end else if (clr) begin
            cnt <= 2'd0;
        end else if (en) begin
            cnt <= cnt + 2'd1;
        end
    end

    assign term = (cnt == 2'(SCAN_BEATS - 1));

endmodule

// File: rtl/mux_scan_serializer.sv
// Latches a 4-bit word, steps a 4:1 mux select 0..3 and emits the sampled
// bits LSB first as a registered serial stream with valid/ready/last.
// Ports: clk, rst_n (sync, active-low); in_data/in_valid/in_ready (word in);
// mux_in/mux_sel (to mux), mux_out (from mux);
// ser_bit/ser_valid/ser_last/ser_ready (serial out).
// Macro SCAN_PARITY_EN appends an even-parity beat (5 beats per word).
module mux_scan_serializer
    import scan_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] mux_in,
    output logic [1:0] mux_sel,
    input  logic       mux_out,
    output logic       ser_bit,
    output logic       ser_valid,
    output logic       ser_last,
    input  logic       ser_ready
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] word_q;
    logic       accept;
    logic       busy;
    logic       cap;
    logic       sel_en;
    logic       sel_clr;
    logic       sel_term;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != IDLE);
    // Capture only when the output register is empty or being drained.
    assign cap      = busy && (!ser_valid || ser_ready);
    assign sel_en   = cap && (state_q == SCAN);
    assign sel_clr  = accept || (sel_en && sel_term);
    assign mux_in   = word_q;

    sel_counter2 u_sel (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sel_clr),
        .en    (sel_en),
        .cnt   (mux_sel),
        .term  (sel_term)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = SCAN;
            end
            SCAN: begin
`ifdef SCAN_PARITY_EN
                if (cap && sel_term) state_d = PARITY;
`else
                if (cap && sel_term) state_d = IDLE;
`endif
            end
`ifdef SCAN_PARITY_EN
            PARITY: begin
                if (cap) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q <= 4'd0;
        end else if (accept) begin
            word_q <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
        end else if (cap) begin
            ser_valid <= 1'b1;
`ifdef SCAN_PARITY_EN
            if (state_q == PARITY) begin
                // Parity comes straight from the word, not via the mux.
                ser_bit  <= ^word_q;
                ser_last <= 1'b1;
            end else begin
                ser_bit  <= mux_out;
                ser_last <= 1'b0;
            end
`else
            ser_bit  <= mux_out;
            ser_last <= sel_term;
`endif
        end else if (ser_valid && ser_ready) begin
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Self-checking bench for mux_scan_serializer: directed steps plus random
// traffic checked against a per-word queue model of the serial stream.
module tb_mux_scan_serializer;

`ifdef SCAN_PARITY_EN
    localparam int BEATS = 5;
`else
    localparam int BEATS = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] mux_in;
    logic [1:0] mux_sel;
    logic       mux_out;
    logic       ser_bit;
    logic       ser_valid;
    logic       ser_last;
    logic       ser_ready;

    typedef struct packed {
        logic b;
        logic last;
    } beat_t;

    beat_t exp_q[$];
    int    vectors    = 0;
    int    miscompares = 0;
    logic  last_acc;

    always #5 clk = ~clk;

    // Environment: the 4:1 mux itself.
    assign mux_out = mux_in[mux_sel];

    mux_scan_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mux_in    (mux_in),
        .mux_sel   (mux_sel),
        .mux_out   (mux_out),
        .ser_bit   (ser_bit),
        .ser_valid (ser_valid),
        .ser_last  (ser_last),
        .ser_ready (ser_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected beats of one word: data LSB first, then optional parity.
    task automatic push_word(input logic [3:0] w);
        beat_t e;
        for (int i = 0; i < 4; i++) begin
            e.b    = w[i];
            e.last = (i == BEATS - 1);
            exp_q.push_back(e);
        end
        if (BEATS == 5) begin
            e.b    = ($countones(w) % 2) == 1;
            e.last = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // One clock: observe handshakes at negedge, advance to just past posedge.
    task automatic tick();
        beat_t e;
        logic  fo;
        logic  fi;
        logic [3:0] w;
        @(negedge clk);
        fo = ser_valid && ser_ready;
        fi = in_valid && in_ready;
        w  = in_data;
        last_acc = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (fo) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {31'd0, ser_bit}, 32'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("ser_bit", {31'd0, ser_bit}, {31'd0, e.b});
                    check("ser_last", {31'd0, ser_last}, {31'd0, e.last});
                end
            end
            if (fi) begin
                push_word(w);
                last_acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        ser_ready = 1'b1;
        in_valid  = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || ser_valid) && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_valid_low"}, {31'd0, ser_valid}, 0);
    endtask

    initial begin
        int low;
        int n;
        rst_n     = 1'b0;
        in_data   = 4'd0;
        in_valid  = 1'b0;
        ser_ready = 1'b1;
        tick();
        tick();
        check("rst_ser_valid", {31'd0, ser_valid}, 0);
        check("rst_ser_last", {31'd0, ser_last}, 0);
        check("rst_ser_bit", {31'd0, ser_bit}, 0);
        check("rst_mux_sel", {30'd0, mux_sel}, 0);
        check("rst_mux_in", {28'd0, mux_in}, 0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 1);

        // Single word, free-running output.
        in_data  = 4'b1011;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t1_accepted", {31'd0, last_acc}, 1);
        check("t1_mux_in", {28'd0, mux_in}, 32'hB);
        low = 0;
        for (int i = 0; i < 12; i++) begin
            if (in_ready) break;
            low++;
            tick();
        end
        check("t1_in_ready_low", low, BEATS);
        drain("t1");

        // Same word with a 3-cycle stall after beat 2.
        in_data  = 4'b1011;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        ser_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_stall_sel", {30'd0, mux_sel}, 2);
            check("t2_stall_bit", {31'd0, ser_bit}, 1);
            check("t2_stall_valid", {31'd0, ser_valid}, 1);
        end
        drain("t2");

        // Back-to-back words with in_valid held.
        in_data  = 4'hA;
        in_valid = 1'b1;
        tick();
        check("t3_first_acc", {31'd0, last_acc}, 1);
        in_data = 4'h5;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (last_acc) break;
        end
        check("t3_gap", n, BEATS + 1);
        drain("t3");

        // Reset mid-scan drops the word.
        in_data  = 4'hF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t4_valid", {31'd0, ser_valid}, 0);
        check("t4_sel", {30'd0, mux_sel}, 0);
        check("t4_in_ready", {31'd0, in_ready}, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t4_no_beat", {31'd0, ser_valid | ser_last}, 0);
        end

        // Parity-zero word (also a plain word in the default build).
        in_data  = 4'b0011;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        drain("t5");

        // Random traffic with random backpressure.
        for (int i = 0; i < 500; i++) begin
            in_data   = 4'($urandom_range(0, 15));
            in_valid  = ($urandom_range(0, 2) != 0);
            ser_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (in_ready == 1'b0) begin
                check("rnd_sel_range", {31'd0, mux_sel > 2'd3}, 0);
            end
        end
        drain("rnd");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
